// File: rtl/aud_pkg.sv
// Shared definitions for the tone sequencer: FSM encoding, note-table field layout
// and an elaboration-time clog2.
package aud_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_PLAY,
        ST_DONE
    } state_t;

    // Ceiling log2; returns 0 for v <= 1.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Entry layout: {dur, div[NUM_CH-1], ..., div[0]}
    function automatic int div_lsb(input int ch, input int div_w);
        return ch * div_w;
    endfunction

    function automatic int dur_lsb(input int num_ch, input int div_w);
        return num_ch * div_w;
    endfunction

endpackage

// File: rtl/aud_tone_ch.sv
// One square-wave tone channel: the period is reloaded (and phase reset) on every
// load strobe, and the output is forced low whenever the channel is not enabled.
module aud_tone_ch #(
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] div,
    input  logic             load,
    input  logic             en,
    output logic             square
);

    logic [DIV_W-2:0] half_reg;
    logic [DIV_W-2:0] count_reg;
    logic             rest_reg;
    logic             sq_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            half_reg  <= '0;
            count_reg <= '0;
            rest_reg  <= 1'b1;
            sq_reg    <= 1'b0;
        end else if (load) begin
            half_reg  <= div[DIV_W-1:1];
            count_reg <= (DIV_W-1)'(1);
            rest_reg  <= (div < DIV_W'(2));
            sq_reg    <= 1'b0;
        end else if (!en || rest_reg) begin
            sq_reg <= 1'b0;
        end else if (count_reg == half_reg) begin
            sq_reg    <= ~sq_reg;
            count_reg <= (DIV_W-1)'(1);
        end else begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign square = sq_reg & en;

endmodule

// File: rtl/aud_seq_synth.sv
// Multi-channel square-wave tone sequencer: note table RAM, tick prescaler, playback
// FSM and two first-order delta-sigma mixers driving the 1-bit audio pins.
module aud_seq_synth
    import aud_pkg::*;
#(
    parameter int CLK_HZ  = 50000000,
    parameter int TICK_HZ = 100,
    parameter int NUM_CH  = 2,
    parameter int DIV_W   = 24,
    parameter int DUR_W   = 8,
    parameter int DEPTH   = 16
) (
    input  logic                          clk50_i,
    input  logic                          rst_n_i,
    input  logic                          wr_en_i,
    input  logic [clog2(DEPTH)-1:0]       wr_addr_i,
    input  logic [DUR_W+NUM_CH*DIV_W-1:0] wr_data_i,
    input  logic                          start_i,
    input  logic                          stop_i,
    input  logic                          loop_i,
    input  logic                          stereo_i,
    output logic                          busy_o,
    output logic [clog2(DEPTH)-1:0]       step_o,
    output logic                          done_o,
    output logic                          audio_l_o,
    output logic                          audio_r_o
);

    localparam int AW       = clog2(DEPTH);
    localparam int ENT_W    = DUR_W + NUM_CH * DIV_W;
    localparam int DUR_LSB  = dur_lsb(NUM_CH, DIV_W);
    localparam int TICK_CYC = CLK_HZ / TICK_HZ;
    localparam int PW       = clog2(TICK_CYC);
    localparam int SW       = clog2(NUM_CH + 1);
    localparam int ACC_W    = clog2(2 * NUM_CH);
    localparam int MW       = ACC_W + 1;

    state_t           state_reg;
    logic [AW-1:0]    step_reg;
    logic [PW-1:0]    presc_reg;
    logic [DUR_W-1:0] tick_cnt_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             stereo_reg;

    logic [ENT_W-1:0] table_mem [DEPTH];
    logic [ENT_W-1:0] entry_reg;
    logic [DUR_W-1:0] entry_dur;
    logic             tick_end;
    logic             last_tick;

    // Entry is captured only in FETCH so host writes never disturb the step in progress.
    always_ff @(posedge clk50_i) begin
        if (wr_en_i) begin
            table_mem[wr_addr_i] <= wr_data_i;
        end
        if (state_reg == ST_FETCH) begin
            entry_reg <= table_mem[step_reg];
        end
    end

    assign entry_dur = entry_reg[DUR_LSB +: DUR_W];
    assign tick_end  = (presc_reg == PW'(TICK_CYC - 1));
    assign last_tick = tick_end && (DUR_W'(tick_cnt_reg + 1'b1) == entry_dur);

    always_ff @(posedge clk50_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg    <= ST_IDLE;
            step_reg     <= '0;
            presc_reg    <= '0;
            tick_cnt_reg <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            stereo_reg   <= 1'b0;
        end else begin
            done_reg   <= 1'b0;
            stereo_reg <= stereo_i;
            if (stop_i && state_reg != ST_IDLE) begin
                state_reg <= ST_IDLE;
                busy_reg  <= 1'b0;
            end else if (start_i && !stop_i) begin
                state_reg    <= ST_FETCH;
                step_reg     <= '0;
                presc_reg    <= '0;
                tick_cnt_reg <= '0;
                busy_reg     <= 1'b1;
            end else begin
                case (state_reg)
                    ST_FETCH: state_reg <= ST_LOAD;
                    ST_LOAD: begin
                        if (entry_dur == '0) begin
                            state_reg <= ST_DONE;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg <= ST_PLAY;
                        end
                    end
                    ST_PLAY: begin
                        if (!tick_end) begin
                            presc_reg <= presc_reg + 1'b1;
                        end else begin
                            presc_reg <= '0;
                            if (!last_tick) begin
                                tick_cnt_reg <= tick_cnt_reg + 1'b1;
                            end else begin
                                tick_cnt_reg <= '0;
                                if (step_reg != AW'(DEPTH - 1)) begin
                                    step_reg  <= step_reg + 1'b1;
                                    state_reg <= ST_FETCH;
                                end else if (loop_i) begin
                                    step_reg  <= '0;
                                    state_reg <= ST_FETCH;
                                end else begin
                                    state_reg <= ST_DONE;
                                    busy_reg  <= 1'b0;
                                    done_reg  <= 1'b1;
                                end
                            end
                        end
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

    logic [NUM_CH-1:0] sq;
    logic              ch_load;
    logic              ch_en;

    assign ch_load = (state_reg == ST_LOAD);
    assign ch_en   = (state_reg == ST_PLAY);

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        aud_tone_ch #(.DIV_W(DIV_W)) u_ch (
            .clk    (clk50_i),
            .rst_n  (rst_n_i),
            .div    (entry_reg[div_lsb(gi, DIV_W) +: DIV_W]),
            .load   (ch_load),
            .en     (ch_en),
            .square (sq[gi])
        );
    end

    logic [SW-1:0] sum_all;
    logic [SW-1:0] sum_even;
    logic [SW-1:0] sum_odd;

    always_comb begin
        sum_all  = '0;
        sum_even = '0;
        sum_odd  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sum_all = sum_all + SW'(sq[i]);
            if (i % 2 == 0) begin
                sum_even = sum_even + SW'(sq[i]);
            end else begin
                sum_odd = sum_odd + SW'(sq[i]);
            end
        end
    end

    // Index 0 drives the left pin (even channels in stereo), index 1 the right pin.
    for (genvar gi = 0; gi < 2; gi++) begin : g_mix
        logic [SW-1:0]    s;
        logic [SW-1:0]    n;
        logic [MW-1:0]    acc_sum;
        logic [ACC_W-1:0] acc_reg;
        logic             pin_reg;

        assign s = stereo_i ? ((gi == 0) ? sum_even : sum_odd) : sum_all;
        assign n = stereo_i ? ((gi == 0) ? SW'((NUM_CH + 1) / 2) : SW'(NUM_CH / 2))
                            : SW'(NUM_CH);
        assign acc_sum = MW'(acc_reg) + MW'(s);

        always_ff @(posedge clk50_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                acc_reg <= '0;
                pin_reg <= 1'b0;
            end else if (stereo_i != stereo_reg) begin
                acc_reg <= '0;
                pin_reg <= 1'b0;
            end else if (n != '0 && acc_sum >= MW'(n)) begin
                acc_reg <= ACC_W'(acc_sum - MW'(n));
                pin_reg <= 1'b1;
            end else begin
                acc_reg <= ACC_W'(acc_sum);
                pin_reg <= 1'b0;
            end
        end
    end

    assign busy_o    = busy_reg;
    assign step_o    = step_reg;
    assign done_o    = done_reg;
    assign audio_l_o = g_mix[0].pin_reg;
    assign audio_r_o = g_mix[1].pin_reg;

endmodule
